// File: rtl/axi_ad_jesd_tx_framer_pkg.sv
// Shared definitions for the DAC-side JESD transmit framer: source codes,
// beat geometry and the combinational generator/packer helpers.
package axi_ad_jesd_tx_framer_pkg;

  // Sample source selector codes
  typedef enum logic [1:0] {
    SRC_DMA   = 2'd0,
    SRC_CONST = 2'd1,
    SRC_RAMP  = 2'd2,
    SRC_PN9   = 2'd3
  } src_sel_e;

  localparam int NUM_CH     = 2;
  localparam int SMP_W      = 16;
  localparam int SMP_PER_CH = 4;
  localparam int CH_W       = SMP_W * SMP_PER_CH;
  localparam int LANE_W     = 2 * SMP_W;
  localparam int LINK_W     = NUM_CH * CH_W;

  // One beat of PN9 output plus the LFSR state left behind
  typedef struct packed {
    logic [CH_W-1:0] data;
    logic [8:0]      state;
  } pn9_res_t;

  // Run x^9 + x^5 + 1 for one full channel beat; the first bit produced
  // goes to the MSB so the stream reads left to right.
  function automatic pn9_res_t pn9_step(input logic [8:0] seed);
    pn9_res_t   r;
    logic [8:0] s;
    logic       b;
    r = '0;
    s = seed;
    for (int i = 0; i < CH_W; i++) begin
      b              = s[8] ^ s[4];
      r.data[CH_W-1-i] = b;
      s              = {s[7:0], b};
    end
    r.state = s;
    return r;
  endfunction

  // Ramp beat: sample k = base + k, wrapping at 16 bits
  function automatic logic [CH_W-1:0] ramp_beat(input logic [SMP_W-1:0] base);
    logic [CH_W-1:0] r;
    r = '0;
    for (int k = 0; k < SMP_PER_CH; k++)
      r[k*SMP_W +: SMP_W] = base + SMP_W'(k);
    return r;
  endfunction

  // Two samples per lane, each sample sent high byte first
  function automatic logic [CH_W-1:0] lane_pack(input logic [CH_W-1:0] ch);
    logic [CH_W-1:0]  r;
    logic [SMP_W-1:0] e;
    logic [SMP_W-1:0] o;
    r = '0;
    for (int l = 0; l < CH_W / LANE_W; l++) begin
      e = ch[l*LANE_W +: SMP_W];
      o = ch[l*LANE_W + SMP_W +: SMP_W];
      r[l*LANE_W +: LANE_W] = {o[7:0], o[15:8], e[7:0], e[15:8]};
    end
    return r;
  endfunction

endpackage

// File: rtl/ad_tx_skid_fifo.sv
// Small synchronous FIFO between the DMA read side and the framer output
// register. A flush empties it; a push in the flush cycle is kept as the
// first fresh entry.
module ad_tx_skid_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_nxt_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wptr_q, wptr_d, rptr_q, rptr_d, waddr;
  logic [AW:0]                 cnt_q, cnt_d;
  logic                        full, do_push, do_pop;

  assign empty_o    = (cnt_q == '0);
  assign full       = (cnt_q == (AW+1)'(DEPTH));
  assign full_nxt_o = (cnt_d == (AW+1)'(DEPTH));
  assign rdata_o    = mem_q[rptr_q];

  // Pointer and occupancy next-state, flush overriding normal traffic
  always_comb begin
    do_push = push_i & ~full;
    do_pop  = pop_i & ~empty_o & ~flush_i;
    waddr   = flush_i ? '0 : wptr_q;
    if (flush_i) begin
      rptr_d = '0;
      wptr_d = AW'(do_push);
      cnt_d  = (AW+1)'(do_push);
    end else begin
      rptr_d = rptr_q + AW'(do_pop);
      wptr_d = wptr_q + AW'(do_push);
      cnt_d  = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[waddr] <= wdata_i;
  end

endmodule

// File: rtl/axi_ad_jesd_tx_framer.sv
// DAC transmit framer: picks DMA, constant, ramp or PN9 samples per beat,
// blanks disabled channels, packs them onto four JESD lanes and tracks
// DMA underflow.
module axi_ad_jesd_tx_framer
  import axi_ad_jesd_tx_framer_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [8:0] PN_SEED    = 9'h1ff
) (
  input  logic         tx_clk,
  input  logic         tx_rstn,
  input  logic         dac_valid,
  output logic         dac_ready,
  input  logic [63:0]  dac_data_0,
  input  logic [63:0]  dac_data_1,
  input  logic         dac_enable_0,
  input  logic         dac_enable_1,
  input  logic [1:0]   dac_src_sel,
  input  logic [15:0]  dac_const_0,
  input  logic [15:0]  dac_const_1,
  input  logic         dac_dunf_clr,
  output logic         dac_dunf,
  output logic [15:0]  dac_dunf_cnt,
  output logic [127:0] tx_data,
  output logic         tx_valid,
  input  logic         tx_ready
);

  src_sel_e                        sel, src_q, src_d;
  logic                            advance, sel_chg, flush, pop, unf, push;
  logic [LINK_W-1:0]               fifo_rdata;
  logic                            fifo_empty, fifo_full_nxt;
  logic [NUM_CH-1:0]               en;
  logic [NUM_CH-1:0][SMP_W-1:0]    cst;
  logic [NUM_CH-1:0][SMP_W-1:0]    base_q, base_d, base_cur;
  logic [NUM_CH-1:0][8:0]          pn_q, pn_d, pn_cur;
  pn9_res_t [NUM_CH-1:0]           pn_res;
  logic [NUM_CH-1:0][CH_W-1:0]     raw, ch_beat;
  logic [LINK_W-1:0]               tx_data_q, tx_data_d;
  logic                            tx_valid_q, dac_ready_q;
  logic                            dunf_q, dunf_d;
  logic [15:0]                     dunf_cnt_q, dunf_cnt_d;

  assign en        = {dac_enable_1, dac_enable_0};
  assign cst       = {dac_const_1, dac_const_0};
  assign push      = dac_valid & dac_ready_q;

  assign dac_ready    = dac_ready_q;
  assign dac_dunf     = dunf_q;
  assign dac_dunf_cnt = dunf_cnt_q;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;

  ad_tx_skid_fifo #(
    .WIDTH (LINK_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (tx_clk),
    .rst_ni     (tx_rstn),
    .flush_i    (flush),
    .push_i     (push),
    .wdata_i    ({dac_data_1, dac_data_0}),
    .pop_i      (pop),
    .rdata_o    (fifo_rdata),
    .empty_o    (fifo_empty),
    .full_nxt_o (fifo_full_nxt)
  );

  // Beat control: the selector is only acted on when the link takes a beat.
  // Re-entering DMA mode flushes stale entries and sends one zero beat that
  // is not counted as underflow.
  always_comb begin
    sel     = src_sel_e'(dac_src_sel);
    advance = tx_ready;
    sel_chg = (sel != src_q);
    flush   = advance & (sel == SRC_DMA) & (src_q != SRC_DMA);
    pop     = advance & (sel == SRC_DMA) & ~flush & ~fifo_empty;
    unf     = advance & (sel == SRC_DMA) & ~flush & fifo_empty;
    src_d   = advance ? sel : src_q;
  end

  // Per-channel source mux and generator next-state; generators keep
  // stepping for a disabled channel, only its output is blanked.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      base_cur[c] = sel_chg ? '0 : base_q[c];
      pn_cur[c]   = sel_chg ? PN_SEED : pn_q[c];
      pn_res[c]   = pn9_step(pn_cur[c]);
      case (sel)
        SRC_DMA:   raw[c] = pop ? fifo_rdata[c*CH_W +: CH_W] : '0;
        SRC_CONST: raw[c] = {SMP_PER_CH{cst[c]}};
        SRC_RAMP:  raw[c] = ramp_beat(base_cur[c]);
        default:   raw[c] = pn_res[c].data;
      endcase
      ch_beat[c] = en[c] ? raw[c] : '0;
      base_d[c]  = base_q[c];
      pn_d[c]    = pn_q[c];
      if (advance) begin
        base_d[c] = (sel == SRC_RAMP) ? base_cur[c] + SMP_W'(SMP_PER_CH) : base_cur[c];
        pn_d[c]   = (sel == SRC_PN9) ? pn_res[c].state : pn_cur[c];
      end
    end
  end

  // Output register next value: hold unless the link consumes a beat
  always_comb begin
    tx_data_d = tx_data_q;
    if (advance) begin
      for (int c = 0; c < NUM_CH; c++)
        tx_data_d[c*CH_W +: CH_W] = lane_pack(ch_beat[c]);
    end
  end

  // Sticky underflow flag and saturating count; clear has priority
  always_comb begin
    dunf_d     = dunf_q;
    dunf_cnt_d = dunf_cnt_q;
    if (dac_dunf_clr) begin
      dunf_d     = 1'b0;
      dunf_cnt_d = '0;
    end else if (unf) begin
      dunf_d = 1'b1;
      if (dunf_cnt_q != 16'hffff) dunf_cnt_d = dunf_cnt_q + 16'd1;
    end
  end

  // Framer state registers
  always_ff @(posedge tx_clk or negedge tx_rstn) begin
    if (!tx_rstn) begin
      src_q       <= SRC_DMA;
      base_q      <= '0;
      pn_q        <= {NUM_CH{PN_SEED}};
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      dac_ready_q <= 1'b0;
      dunf_q      <= 1'b0;
      dunf_cnt_q  <= '0;
    end else begin
      src_q       <= src_d;
      base_q      <= base_d;
      pn_q        <= pn_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= 1'b1;
      dac_ready_q <= ~fifo_full_nxt;
      dunf_q      <= dunf_d;
      dunf_cnt_q  <= dunf_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_ad_jesd_tx_framer.sv
// Self-checking bench for axi_ad_jesd_tx_framer with a queue-based
// behavioural model of the framer.
module tb_axi_ad_jesd_tx_framer;

  localparam int DEPTH = 4;

  logic         tx_clk, tx_rstn, dac_valid, dac_ready;
  logic [63:0]  dac_data_0, dac_data_1;
  logic         dac_enable_0, dac_enable_1;
  logic [1:0]   dac_src_sel;
  logic [15:0]  dac_const_0, dac_const_1;
  logic         dac_dunf_clr, dac_dunf;
  logic [15:0]  dac_dunf_cnt;
  logic [127:0] tx_data;
  logic         tx_valid, tx_ready;

  int n_checks = 0;
  int n_fail   = 0;

  axi_ad_jesd_tx_framer dut (
    .tx_clk       (tx_clk),
    .tx_rstn      (tx_rstn),
    .dac_valid    (dac_valid),
    .dac_ready    (dac_ready),
    .dac_data_0   (dac_data_0),
    .dac_data_1   (dac_data_1),
    .dac_enable_0 (dac_enable_0),
    .dac_enable_1 (dac_enable_1),
    .dac_src_sel  (dac_src_sel),
    .dac_const_0  (dac_const_0),
    .dac_const_1  (dac_const_1),
    .dac_dunf_clr (dac_dunf_clr),
    .dac_dunf     (dac_dunf),
    .dac_dunf_cnt (dac_dunf_cnt),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  // ---------------- reference model ----------------
  logic [127:0] m_q[$];
  logic [127:0] m_tx;
  bit           m_valid, m_ready, m_dunf;
  int           m_cnt;
  logic [1:0]   m_src;
  int           m_base;
  bit           m_pn[$];   // last nine PN bits, oldest first

  function automatic void pn_restart();
    m_pn.delete();
    for (int i = 0; i < 9; i++) m_pn.push_back(1'b1);
  endfunction

  // b[n] = b[n-9] ^ b[n-5]
  function automatic bit pn_next();
    bit b;
    b = m_pn[0] ^ m_pn[4];
    m_pn.push_back(b);
    void'(m_pn.pop_front());
    return b;
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_tx = '0; m_valid = 0; m_ready = 0; m_dunf = 0; m_cnt = 0;
    m_src = 2'd0; m_base = 0;
    pn_restart();
  endfunction

  // smp[c*4 + k] = channel c sample k
  function automatic logic [127:0] pack(input logic [15:0] smp [8]);
    logic [127:0] r;
    logic [15:0]  e, o;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      e = smp[(l/2)*4 + (l%2)*2];
      o = smp[(l/2)*4 + (l%2)*2 + 1];
      r[32*l +: 8]      = e[15:8];
      r[32*l + 8 +: 8]  = e[7:0];
      r[32*l + 16 +: 8] = o[15:8];
      r[32*l + 24 +: 8] = o[7:0];
    end
    return r;
  endfunction

  // Update the model with the inputs in effect, then let the clock edge pass.
  task automatic tick();
    logic [15:0]  smp [8];
    logic [127:0] beat;
    logic [63:0]  w;
    logic [1:0]   sel;
    bit           push, unf;
    push = dac_valid && m_ready;
    unf  = 0;
    if (tx_ready) begin
      sel = dac_src_sel;
      for (int i = 0; i < 8; i++) smp[i] = '0;
      if (sel != m_src) begin m_base = 0; pn_restart(); end
      case (sel)
        2'd0: begin
          if (m_src != 2'd0) m_q.delete();
          else if (m_q.size() > 0) begin
            beat = m_q.pop_front();
            for (int i = 0; i < 8; i++) smp[i] = beat[16*i +: 16];
          end else unf = 1;
        end
        2'd1: for (int k = 0; k < 4; k++) begin smp[k] = dac_const_0; smp[4+k] = dac_const_1; end
        2'd2: begin
          for (int k = 0; k < 4; k++) begin smp[k] = 16'(m_base + k); smp[4+k] = 16'(m_base + k); end
          m_base = (m_base + 4) % 65536;
        end
        default: begin
          for (int i = 0; i < 64; i++) w[63-i] = pn_next();
          for (int k = 0; k < 4; k++) begin smp[k] = w[16*k +: 16]; smp[4+k] = w[16*k +: 16]; end
        end
      endcase
      if (!dac_enable_0) for (int k = 0; k < 4; k++) smp[k] = '0;
      if (!dac_enable_1) for (int k = 0; k < 4; k++) smp[4+k] = '0;
      m_tx  = pack(smp);
      m_src = sel;
      if (unf) begin m_dunf = 1; if (m_cnt < 65535) m_cnt++; end
    end
    if (dac_dunf_clr) begin m_dunf = 0; m_cnt = 0; end
    if (push) m_q.push_back({dac_data_1, dac_data_0});
    m_valid = 1;
    m_ready = (m_q.size() < DEPTH);
    @(posedge tx_clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tx_rstn = 0; model_reset();
    repeat (2) @(posedge tx_clk); #1;
    n_checks++; if (tx_data !== 128'd0) begin n_fail++; $display("FAIL rst_tx_data got %h exp 0", tx_data); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid got %b exp 0", tx_valid); end
    n_checks++; if (dac_ready !== 1'b0) begin n_fail++; $display("FAIL rst_dac_ready got %b exp 0", dac_ready); end
    n_checks++; if (dac_dunf !== 1'b0) begin n_fail++; $display("FAIL rst_dunf got %b exp 0", dac_dunf); end
    n_checks++; if (dac_dunf_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_dunf_cnt got %0d exp 0", dac_dunf_cnt); end
    tx_rstn = 1;
    tick();
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL rel_tx_valid got %b exp 1", tx_valid); end
    n_checks++; if (dac_ready !== 1'b1) begin n_fail++; $display("FAIL rel_dac_ready got %b exp 1", dac_ready); end
  endtask

  task automatic test_lane_map();
    dac_src_sel = 2'd0; dac_enable_0 = 1; dac_enable_1 = 1;
    dac_data_0 = 64'h0000_0000_5678_1234; dac_data_1 = '0;
    dac_valid = 1; tx_ready = 1;
    tick();
    dac_valid = 0;
    tick();
    n_checks++; if (tx_data !== {96'd0, 32'h7856_3412}) begin n_fail++; $display("FAIL lane_map got %h exp %h", tx_data, {96'd0, 32'h7856_3412}); end
    n_checks++; if (tx_data !== m_tx) begin n_fail++; $display("FAIL lane_map_model got %h exp %h", tx_data, m_tx); end
    tx_ready = 0; dac_dunf_clr = 1;
    tick();
    dac_dunf_clr = 0;
  endtask

  task automatic test_backpressure();
    int acc = 0;
    tx_ready = 0; dac_src_sel = 2'd0;
    for (int i = 0; i < 5; i++) begin
      dac_valid  = 1;
      dac_data_0 = {$urandom, $urandom};
      dac_data_1 = {$urandom, $urandom};
      if (dac_ready === 1'b1) acc++;
      tick();
    end
    dac_valid = 0;
    n_checks++; if (acc !== 4) begin n_fail++; $display("FAIL bp_accepted got %0d exp 4", acc); end
    n_checks++; if (dac_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b exp 0", dac_ready); end
    tx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (tx_data !== m_tx) begin n_fail++; $display("FAIL bp_beat%0d got %h exp %h", i, tx_data, m_tx); end
    end
    tx_ready = 0;
    n_checks++; if (dac_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back got %b exp 1", dac_ready); end
  endtask

  task automatic test_underflow();
    dac_dunf_clr = 1; tick(); dac_dunf_clr = 0;
    dac_src_sel = 2'd0; tx_ready = 1;
    repeat (3) tick();
    tx_ready = 0;
    n_checks++; if (tx_data !== 128'd0) begin n_fail++; $display("FAIL unf_data got %h exp 0", tx_data); end
    n_checks++; if (dac_dunf !== 1'b1) begin n_fail++; $display("FAIL unf_flag got %b exp 1", dac_dunf); end
    n_checks++; if (dac_dunf_cnt !== 16'd3) begin n_fail++; $display("FAIL unf_cnt got %0d exp 3", dac_dunf_cnt); end
    dac_dunf_clr = 1; tick(); dac_dunf_clr = 0;
    n_checks++; if (dac_dunf !== 1'b0) begin n_fail++; $display("FAIL unf_clr_flag got %b exp 0", dac_dunf); end
    n_checks++; if (dac_dunf_cnt !== 16'd0) begin n_fail++; $display("FAIL unf_clr_cnt got %0d exp 0", dac_dunf_cnt); end
  endtask

  task automatic test_ramp();
    logic [127:0] held;
    dac_src_sel = 2'd2; tx_ready = 1;
    tick();
    n_checks++; if (tx_data[31:0] !== 32'h0100_0000) begin n_fail++; $display("FAIL ramp_b1_lane0 got %h exp 01000000", tx_data[31:0]); end
    n_checks++; if (tx_data !== m_tx) begin n_fail++; $display("FAIL ramp_b1 got %h exp %h", tx_data, m_tx); end
    tick();
    n_checks++; if (tx_data[63:0] !== 64'h0700_0600_0500_0400) begin n_fail++; $display("FAIL ramp_b2_ch0 got %h exp 0700060005000400", tx_data[63:0]); end
    n_checks++; if (tx_data !== m_tx) begin n_fail++; $display("FAIL ramp_b2 got %h exp %h", tx_data, m_tx); end
    held = m_tx;
    tx_ready = 0;
    repeat (3) begin
      tick();
      n_checks++; if (tx_data !== held) begin n_fail++; $display("FAIL ramp_stall got %h exp %h", tx_data, held); end
    end
    tx_ready = 1;
    tick();
    n_checks++; if (tx_data[31:0] !== 32'h0900_0800) begin n_fail++; $display("FAIL ramp_b3_lane0 got %h exp 09000800", tx_data[31:0]); end
    n_checks++; if (tx_data !== m_tx) begin n_fail++; $display("FAIL ramp_b3 got %h exp %h", tx_data, m_tx); end
    tx_ready = 0;
  endtask

  task automatic test_pn9_enables();
    logic [127:0] first;
    dac_src_sel = 2'd3; dac_enable_1 = 0; tx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) first = m_tx;
      n_checks++; if (tx_data !== m_tx) begin n_fail++; $display("FAIL pn_beat%0d got %h exp %h", i, tx_data, m_tx); end
      n_checks++; if (tx_data[127:64] !== 64'd0) begin n_fail++; $display("FAIL pn_ch1_off got %h exp 0", tx_data[127:64]); end
    end
    dac_src_sel = 2'd1; dac_const_0 = 16'($urandom); dac_const_1 = 16'($urandom);
    tick();
    n_checks++; if (tx_data !== m_tx) begin n_fail++; $display("FAIL const_beat got %h exp %h", tx_data, m_tx); end
    dac_src_sel = 2'd3;
    tick();
    n_checks++; if (tx_data !== first) begin n_fail++; $display("FAIL pn_restart got %h exp %h", tx_data, first); end
    tick();
    n_checks++; if (tx_data !== m_tx) begin n_fail++; $display("FAIL pn_after_restart got %h exp %h", tx_data, m_tx); end
    tx_ready = 0; dac_enable_1 = 1;
  endtask

  task automatic test_random();
    dac_src_sel = 2'd0;
    for (int i = 0; i < 400; i++) begin
      dac_valid    = ($urandom % 3) != 0;
      dac_data_0   = {$urandom, $urandom};
      dac_data_1   = {$urandom, $urandom};
      tx_ready     = ($urandom % 4) != 0;
      dac_const_0  = 16'($urandom);
      dac_const_1  = 16'($urandom);
      dac_dunf_clr = ($urandom % 25) == 0;
      if ($urandom % 20 == 0) dac_src_sel = 2'($urandom_range(0, 3));
      if ($urandom % 20 == 0) begin dac_enable_0 = 1'($urandom); dac_enable_1 = 1'($urandom); end
      tick();
      n_checks++;
      if ({tx_data, tx_valid, dac_ready, dac_dunf, dac_dunf_cnt} !== {m_tx, m_valid, m_ready, m_dunf, 16'(m_cnt)}) begin
        n_fail++;
        $display("FAIL random_cyc%0d got %h/%b%b%b/%0d exp %h/%b%b%b/%0d", i, tx_data, tx_valid, dac_ready,
                 dac_dunf, dac_dunf_cnt, m_tx, m_valid, m_ready, m_dunf, m_cnt);
      end
    end
    dac_valid = 0; dac_dunf_clr = 0; tx_ready = 0; dac_enable_0 = 1; dac_enable_1 = 1;
  endtask

  task automatic test_reset_midrun();
    dac_src_sel = 2'd0; tx_ready = 1;
    repeat (6) tick();
    dac_src_sel = 2'd2; tx_ready = 0; dac_valid = 1;
    repeat (2) tick();
    dac_valid = 0; tx_ready = 1;
    tick();
    tx_ready = 0;
    tx_rstn = 0; model_reset();
    #1;
    n_checks++; if (tx_data !== 128'd0) begin n_fail++; $display("FAIL mid_rst_data got %h exp 0", tx_data); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b exp 0", tx_valid); end
    n_checks++; if (dac_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready got %b exp 0", dac_ready); end
    n_checks++; if ({dac_dunf, dac_dunf_cnt} !== 17'd0) begin n_fail++; $display("FAIL mid_rst_dunf got %b/%0d exp 0/0", dac_dunf, dac_dunf_cnt); end
    repeat (2) @(posedge tx_clk); #1;
    tx_rstn = 1; tx_ready = 1; dac_src_sel = 2'd2;
    tick();
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL mid_rel_valid got %b exp 1", tx_valid); end
    n_checks++; if (tx_data[31:0] !== 32'h0100_0000) begin n_fail++; $display("FAIL mid_ramp_restart got %h exp 01000000", tx_data[31:0]); end
    n_checks++; if (dac_ready !== 1'b1) begin n_fail++; $display("FAIL mid_fifo_empty_ready got %b exp 1", dac_ready); end
    dac_src_sel = 2'd0;
    repeat (2) begin
      tick();
      n_checks++;
      if ({tx_data, dac_dunf, dac_dunf_cnt} !== {m_tx, m_dunf, 16'(m_cnt)}) begin
        n_fail++;
        $display("FAIL mid_dma_after got %h/%b/%0d exp %h/%b/%0d", tx_data, dac_dunf, dac_dunf_cnt, m_tx, m_dunf, m_cnt);
      end
    end
    tx_ready = 0;
  endtask

  initial begin
    tx_rstn = 0; dac_valid = 0; dac_data_0 = '0; dac_data_1 = '0;
    dac_enable_0 = 1; dac_enable_1 = 1; dac_src_sel = 2'd0;
    dac_const_0 = '0; dac_const_1 = '0; dac_dunf_clr = 0; tx_ready = 0;
    test_reset();
    test_lane_map();
    test_backpressure();
    test_underflow();
    test_ramp();
    test_pn9_enables();
    test_random();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
